// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 3-sample majority vote) feeding a FWFT FIFO with an AXI4-Stream master port.
// Define PARITY_CHECK_EN to accept 8E1 frames and report parity errors; the default build receives 8N1 only.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          uart_rxd,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);
    localparam int DIV   = CLK_FREQ_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t state, state_nx;

    logic             rxd_m, rxd_s, rxd_d;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       samp_cnt;
    logic             tick, vote_tick, end_tick;
    logic             s7, s8, maj;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             par_bad;
    logic             shift_en, par_en, stop_ok, push_ok, frame_set, par_set;
    logic             push_req;
    logic [7:0]       push_data;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, pop, wr_en;

    // rxd_d is the previous synchronised sample, used only for start-edge detection.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign vote_tick = tick && (samp_cnt == 4'd9);
    assign end_tick  = tick && (samp_cnt == 4'd15);
    assign maj       = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            div_cnt  <= '0;
            samp_cnt <= 4'd0;
            s7       <= 1'b1;
            s8       <= 1'b1;
        end else begin
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;
            if (state == IDLE) samp_cnt <= 4'd0;
            else if (tick)     samp_cnt <= samp_cnt + 4'd1;
            if (tick && samp_cnt == 4'd7) s7 <= rxd_s;
            if (tick && samp_cnt == 4'd8) s8 <= rxd_s;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (rxd_d && !rxd_s) state_nx = START;
            START:  if (vote_tick && maj) state_nx = IDLE;
                    else if (end_tick)    state_nx = DATA;
`ifdef PARITY_CHECK_EN
            DATA:   if (end_tick && bit_idx == 3'd7) state_nx = PARITY;
`else
            DATA:   if (end_tick && bit_idx == 3'd7) state_nx = STOP;
`endif
            PARITY: if (end_tick) state_nx = STOP;
            STOP:   if (vote_tick) state_nx = maj ? IDLE : BREAK;
            BREAK:  if (rxd_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        shift_en  = (state == DATA) && vote_tick;
        par_en    = (state == PARITY) && vote_tick;
        stop_ok   = (state == STOP) && vote_tick && maj;
        frame_set = (state == STOP) && vote_tick && !maj;
        push_ok   = stop_ok && !par_bad;
        par_set   = stop_ok && par_bad;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            push_req  <= 1'b0;
            push_data <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            if (state == START)               bit_idx <= 3'd0;
            else if (state == DATA && end_tick) bit_idx <= bit_idx + 3'd1;
            if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
            push_req  <= push_ok;
            if (push_ok) push_data <= shift_reg;
            frame_err <= frame_set;
        end
    end

`ifdef PARITY_CHECK_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) par_bad <= maj ^ (^shift_reg);
            parity_err <= par_set;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
    logic unused_par;
    assign unused_par = par_en | par_set;
`endif

    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop   = m_axis_tvalid && m_axis_tready;
    // A push at full is still accepted when the head leaves in the same cycle.
    assign wr_en = push_req && (!full || pop);

    always_ff @(posedge axi_aclk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            overrun_err <= push_req && full && !pop;
        end
    end

    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frame driver, reference FIFO queue, and a monitor that checks every handshake.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int BIT   = 64;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tvalid;
    logic [4:0] fifo_count;
    logic       frame_err, overrun_err, parity_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_frame = 0, exp_ovr = 0, exp_par = 0;
    int obs_frame = 0, obs_ovr = 0, obs_par = 0;
    bit rand_ready = 1'b0;
    logic [7:0] mon_e;
    logic prev_fe = 1'b0, prev_oe = 1'b0, prev_pe = 1'b0;

    uart_rx_fifo #(.CLK_FREQ_HZ(7372800), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .uart_rxd(rxd),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .fifo_count(fifo_count), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Valid/ready: a byte transfers on a cycle where tvalid and tready are both high at the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%02h, expected no byte", tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_data", int'(tdata), int'(mon_e));
                end
            end
            if (frame_err) begin obs_frame++; check("frame_err_width", int'(prev_fe), 0); end
            if (overrun_err) begin obs_ovr++; check("overrun_err_width", int'(prev_oe), 0); end
            if (parity_err) begin obs_par++; check("parity_err_width", int'(prev_pe), 0); end
        end
        prev_fe = frame_err;
        prev_oe = overrun_err;
        prev_pe = parity_err;
    end

    task automatic tick_cycle();
        if (rand_ready) tready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        idle(BIT);
    endtask

    // mode 1: check tvalid latency after the stop decision; mode 2: pop exactly in the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par, input int mode);
        logic good;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit((^b) ^ bad_par);
        good = stop;
        if (!stop) exp_frame++;
        else if (PAR_EN && bad_par) begin good = 1'b0; exp_par++; end
        if (good) begin
            if (exp_q.size() < DEPTH || mode == 2) exp_q.push_back(b);
            else exp_ovr++;
        end
        rxd = stop;
        if (mode == 1) begin
            idle(43);
            check("tvalid_before_push", int'(tvalid), 0);
            tick_cycle();
            check("tvalid_latency", int'(tvalid), 1);
            check("tdata_head", int'(tdata), int'(b));
            idle(BIT - 44);
        end else if (mode == 2) begin
            idle(43);
            check("count_full_before", int'(fifo_count), DEPTH);
            tready = 1'b1;
            tick_cycle();
            tready = 1'b0;
            check("count_simul_push_pop", int'(fifo_count), DEPTH);
            idle(BIT - 44);
        end else begin
            idle(BIT);
        end
    endtask

    task automatic drain();
        int guard;
        tready = 1'b1;
        guard = 0;
        while (tvalid && guard < 200) begin
            tick_cycle();
            guard++;
        end
        check("drain_empty", int'(tvalid), 0);
        check("drain_count", int'(fifo_count), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_tvalid", int'(tvalid), 0);
        check("rst_tdata", int'(tdata), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_errs", int'({frame_err, overrun_err, parity_err}), 0);
        rst_n = 1'b1;
        idle(5);

        // Single byte with latency check
        tready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1);
        idle(20);
        check("single_count", int'(fifo_count), 0);
        check("single_no_err", obs_frame + obs_ovr + obs_par, 0);

        // Glitch rejection
        rxd = 1'b0;
        idle(20);
        rxd = 1'b1;
        idle(100);
        check("glitch_tvalid", int'(tvalid), 0);
        check("glitch_no_frame_err", obs_frame, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        idle(20);
        check("glitch_next_queue", exp_q.size(), 0);

        // Framing error, held break, then recovery
        send_frame(8'h55, 1'b0, 1'b0, 0);
        idle(2000);
        check("break_frame_err", obs_frame, 1);
        check("break_tvalid", int'(tvalid), 0);
        rxd = 1'b1;
        idle(50);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        idle(20);
        check("break_recover_queue", exp_q.size(), 0);

        // Fill and overrun
        tready = 1'b0;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        idle(10);
        check("fill_count", int'(fifo_count), DEPTH);
        check("fill_overrun", obs_ovr, 1);
        drain();

        // Simultaneous push and pop at full
        tready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b0, 0);
        send_frame(8'h80, 1'b1, 1'b0, 2);
        idle(10);
        check("simul_no_overrun", obs_ovr, 1);
        check("simul_count", int'(fifo_count), DEPTH);
        drain();

        // Reset during bit 3 of 0xF0 with two bytes queued
        tready = 1'b0;
        send_frame(8'h21, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check("pre_reset_count", int'(fifo_count), 2);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rxd = 1'b0;
        idle(32);
        rst_n = 1'b0;
        tick_cycle();
        check("midrst_tvalid", int'(tvalid), 0);
        check("midrst_tdata", int'(tdata), 0);
        check("midrst_count", int'(fifo_count), 0);
        check("midrst_errs", int'({frame_err, overrun_err, parity_err}), 0);
        rst_n = 1'b1;
        exp_q.delete();
        idle(BIT - 33);
        for (int i = 4; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        idle(200);
        check("postrst_tvalid", int'(tvalid), 0);
        check("postrst_count", int'(fifo_count), 0);
        tready = 1'b1;
        send_frame(8'h99, 1'b1, 1'b0, 0);
        idle(20);
        check("postrst_queue", exp_q.size(), 0);

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(20);
        check("parity_err_count", obs_par, 1);
        check("parity_no_push", int'(fifo_count), 0);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        idle(20);
`endif

        // Random bytes with random back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            send_frame(8'($urandom), 1'b1, PAR_EN && ($urandom_range(0, 3) == 0), 0);
            idle($urandom_range(3, 40));
        end
        rand_ready = 1'b0;
        drain();

        idle(10);
        check("total_frame_err", obs_frame, exp_frame);
        check("total_overrun_err", obs_ovr, exp_ovr);
        check("total_parity_err", obs_par, exp_par);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
